// File: rtl/conf_uart.sv
// Configurable UART: independent TX and RX engines sharing only the clock and reset.
// Each bit lasts BIT_CLKS cycles; RX samples the synchronised line mid-bit.
module conf_uart #(
  parameter int SYSTEM_FREQ = 50_000_000,
  parameter int BAUD_RATE   = 9600,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clock,
  input  logic                 arst_n,
  input  logic                 rx_bit,
  output logic                 tx_bit,
  output logic [DATA_BITS-1:0] rx_value,
  output logic                 rx_value_ready,
  output logic                 rx_parity_error,
  output logic                 rx_frame_error,
  input  logic [DATA_BITS-1:0] tx_value,
  input  logic                 tx_value_write,
  output logic                 tx_ready
);

  localparam int DIV      = SYSTEM_FREQ / (BAUD_RATE * 16);
  localparam int BIT_CLKS = 16 * DIV;
  localparam int CW       = (BIT_CLKS > 2) ? $clog2(BIT_CLKS) : 1;
  localparam logic [CW-1:0] LAST      = CW'(BIT_CLKS - 1);
  localparam logic [CW-1:0] MID       = CW'(BIT_CLKS / 2 - 1);
  localparam logic [3:0]    DLAST     = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  generate
    if (DIV < 1 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
      $error("conf_uart: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  tx_state_t            tx_state_q;
  logic [CW-1:0]        tx_cnt_q;
  logic [3:0]           tx_idx_q;
  logic [DATA_BITS-1:0] tx_shift_q;
  logic                 tx_par_q;
  logic                 tx_bit_q;
  logic                 tx_ready_q;

  always_ff @(posedge clock or negedge arst_n) begin
    if (!arst_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_bit_q   <= 1'b1;
      tx_ready_q <= 1'b1;
    end else if (tx_state_q == TX_IDLE) begin
      if (tx_value_write && tx_ready_q) begin
        tx_shift_q <= tx_value;
        tx_par_q   <= (PARITY == 1) ? ~(^tx_value) : ^tx_value;
        tx_state_q <= TX_START;
        tx_cnt_q   <= '0;
        tx_bit_q   <= 1'b0;
        tx_ready_q <= 1'b0;
      end
    end else if (tx_cnt_q != LAST) begin
      tx_cnt_q <= tx_cnt_q + 1'b1;
    end else begin
      // End of a bit period: advance to the next bit of the frame.
      tx_cnt_q <= '0;
      case (tx_state_q)
        TX_START: begin
          tx_state_q <= TX_DATA;
          tx_idx_q   <= '0;
          tx_bit_q   <= tx_shift_q[0];
          tx_shift_q <= tx_shift_q >> 1;
        end
        TX_DATA: begin
          if (tx_idx_q != DLAST) begin
            tx_idx_q   <= tx_idx_q + 1'b1;
            tx_bit_q   <= tx_shift_q[0];
            tx_shift_q <= tx_shift_q >> 1;
          end else if (PARITY != 0) begin
            tx_state_q <= TX_PARITY;
            tx_bit_q   <= tx_par_q;
          end else begin
            tx_state_q <= TX_STOP;
            tx_idx_q   <= '0;
            tx_bit_q   <= 1'b1;
          end
        end
        TX_PARITY: begin
          tx_state_q <= TX_STOP;
          tx_idx_q   <= '0;
          tx_bit_q   <= 1'b1;
        end
        TX_STOP: begin
          if (tx_idx_q != STOP_LAST) begin
            tx_idx_q <= tx_idx_q + 1'b1;
          end else begin
            tx_state_q <= TX_IDLE;
            tx_ready_q <= 1'b1;
          end
        end
        default: begin
          tx_state_q <= TX_IDLE;
          tx_bit_q   <= 1'b1;
          tx_ready_q <= 1'b1;
        end
      endcase
    end
  end

  rx_state_t            rx_state_q;
  logic                 rx_sync1_q;
  logic                 rx_sync2_q;
  logic                 rx_prev_q;
  logic [CW-1:0]        rx_cnt_q;
  logic [3:0]           rx_idx_q;
  logic [DATA_BITS-1:0] rx_shift_q;
  logic                 rx_perr_pend_q;
  logic [DATA_BITS-1:0] rx_value_q;
  logic                 rx_ready_q;
  logic                 rx_perr_q;
  logic                 rx_ferr_q;

  always_ff @(posedge clock or negedge arst_n) begin
    if (!arst_n) begin
      rx_state_q     <= RX_IDLE;
      rx_sync1_q     <= 1'b1;
      rx_sync2_q     <= 1'b1;
      rx_prev_q      <= 1'b1;
      rx_cnt_q       <= '0;
      rx_idx_q       <= '0;
      rx_shift_q     <= '0;
      rx_perr_pend_q <= 1'b0;
      rx_value_q     <= '0;
      rx_ready_q     <= 1'b0;
      rx_perr_q      <= 1'b0;
      rx_ferr_q      <= 1'b0;
    end else begin
      rx_sync1_q <= rx_bit;
      rx_sync2_q <= rx_sync1_q;
      rx_prev_q  <= rx_sync2_q;
      rx_ready_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_prev_q && !rx_sync2_q) begin
            rx_state_q <= RX_START;
            rx_cnt_q   <= '0;
          end
        end
        RX_START: begin
          // After the mid-start sample, the counter wraps exactly on later mid-bit points.
          if (rx_cnt_q != MID) begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end else begin
            rx_cnt_q       <= '0;
            rx_idx_q       <= '0;
            rx_perr_pend_q <= 1'b0;
            rx_state_q     <= rx_sync2_q ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (rx_cnt_q != LAST) begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end else begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_sync2_q, rx_shift_q[DATA_BITS-1:1]};
            if (rx_idx_q == DLAST) begin
              rx_state_q <= (PARITY != 0) ? RX_PARITY : RX_STOP;
            end else begin
              rx_idx_q <= rx_idx_q + 1'b1;
            end
          end
        end
        RX_PARITY: begin
          if (rx_cnt_q != LAST) begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end else begin
            rx_cnt_q       <= '0;
            rx_perr_pend_q <= rx_sync2_q != ((PARITY == 1) ? ~(^rx_shift_q) : ^rx_shift_q);
            rx_state_q     <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (rx_cnt_q != LAST) begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end else begin
            rx_cnt_q   <= '0;
            rx_state_q <= RX_IDLE;
            rx_value_q <= rx_shift_q;
            rx_perr_q  <= (PARITY != 0) ? rx_perr_pend_q : 1'b0;
            rx_ferr_q  <= ~rx_sync2_q;
            rx_ready_q <= 1'b1;
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  assign tx_bit          = tx_bit_q;
  assign tx_ready        = tx_ready_q;
  assign rx_value        = rx_value_q;
  assign rx_value_ready  = rx_ready_q;
  assign rx_parity_error = rx_perr_q;
  assign rx_frame_error  = rx_ferr_q;

endmodule
